// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg: shared types and constants for the 8-bit bus machine output stage.
//   out_state_t   : conversion FSM states (IDLE, CONVERT)
//   BCD_ITERS     : double-dabble iterations for an 8-bit binary input
//   SEG_DIGIT     : active-low 7-segment codes {g,f,e,d,c,b,a} for 0..9
//   SEG_BLANK     : all segments off
//   dabble_step() : one double-dabble iteration on the 20-bit shift register
// ---------------------------------------------------------------------------
package sap_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } out_state_t;

    localparam int BCD_ITERS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Shift register layout: [19:16] hundreds, [15:12] tens, [11:8] ones,
    // [7:0] remaining binary bits. Each BCD nibble >= 5 gets +3 before the
    // left shift so that it carries correctly into the next decade.
    function automatic logic [19:0] dabble_step(input logic [19:0] shift_in);
        logic [19:0] adj;
        adj = shift_in;
        for (int i = 0; i < 3; i++) begin
            if (adj[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
            end else begin
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4];
            end
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder: combinational BCD digit to active-low 7-segment pattern.
//   digit [3:0] : BCD digit 0..9 (codes above 9 render blank)
//   blank       : force all segments off (leading-zero blanking)
//   seg   [6:0] : active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_decoder
    import sap_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Digit lookup with blanking override.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (digit <= 4'd9) begin
            seg = SEG_DIGIT[digit];
        end else begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/out_display.sv
// ---------------------------------------------------------------------------
// out_display: output stage of the 8-bit bus machine.
// Latches the bus byte on load, converts it to three BCD digits with a
// sequential double-dabble engine (one iteration per clock, 8 cycles), and
// scans a 3-digit active-low 7-segment display with leading-zero blanking.
//   REFRESH_DIV : clock cycles each digit stays selected (>= 1)
//   clk, rst    : system clock, synchronous active-high reset
//   load, bus   : latch bus byte and (re)start conversion
//   out         : raw output register
//   busy        : conversion in progress
//   bcd         : last completed conversion {hundreds, tens, ones}
//   an          : active-low digit select (bit0 ones, bit1 tens, bit2 hundreds)
//   seg         : active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module out_display
    import sap_pkg::*;
#(
    parameter int REFRESH_DIV = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  bus,
    output logic [7:0]  out,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       ITER_LAST = 4'(BCD_ITERS - 1);

    out_state_t       state_r;
    logic [19:0]      shift_r;
    logic [19:0]      shift_next_s;
    logic [3:0]       iter_r;
    logic [7:0]       out_r;
    logic [11:0]      bcd_r;

    logic [CNT_W-1:0] refresh_cnt_r;
    logic [1:0]       digit_idx_r;
    logic [1:0]       digit_idx_next_s;
    logic [3:0]       digit_s;
    logic             blank_s;
    logic [2:0]       an_next_s;
    logic [6:0]       seg_dec_s;
    logic [2:0]       an_r;
    logic [6:0]       seg_r;

    assign shift_next_s = dabble_step(shift_r);

    // Conversion FSM, shift register and output/bcd registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= 20'd0;
            iter_r  <= 4'd0;
            out_r   <= 8'd0;
            bcd_r   <= 12'd0;
        end else begin
            // Completion commits even if a new load arrives on the same edge.
            if ((state_r == CONVERT) && (iter_r == ITER_LAST)) begin
                bcd_r <= shift_next_s[19:8];
            end else begin
                bcd_r <= bcd_r;
            end

            if (load) begin
                // Latest load wins: restart from the new byte.
                out_r   <= bus;
                shift_r <= {12'd0, bus};
                iter_r  <= 4'd0;
                state_r <= CONVERT;
            end else if (state_r == CONVERT) begin
                out_r   <= out_r;
                shift_r <= shift_next_s;
                iter_r  <= iter_r + 4'd1;
                state_r <= (iter_r == ITER_LAST) ? IDLE : CONVERT;
            end else begin
                out_r   <= out_r;
                shift_r <= shift_r;
                iter_r  <= iter_r;
                state_r <= state_r;
            end
        end
    end

    // Next digit index, selected digit, blanking and anode pattern.
    always_comb begin
        digit_idx_next_s = digit_idx_r;
        digit_s          = 4'd0;
        blank_s          = 1'b0;
        an_next_s        = 3'b110;

        if (refresh_cnt_r == CNT_LAST) begin
            digit_idx_next_s = (digit_idx_r == 2'd2) ? 2'd0 : (digit_idx_r + 2'd1);
        end else begin
            digit_idx_next_s = digit_idx_r;
        end

        case (digit_idx_next_s)
            2'd0: begin
                digit_s   = bcd_r[3:0];
                blank_s   = 1'b0;
                an_next_s = 3'b110;
            end
            2'd1: begin
                digit_s   = bcd_r[7:4];
                blank_s   = (bcd_r[11:4] == 8'd0);
                an_next_s = 3'b101;
            end
            2'd2: begin
                digit_s   = bcd_r[11:8];
                blank_s   = (bcd_r[11:8] == 4'd0);
                an_next_s = 3'b011;
            end
            default: begin
                digit_s   = 4'd0;
                blank_s   = 1'b1;
                an_next_s = 3'b111;
            end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .digit (digit_s),
        .blank (blank_s),
        .seg   (seg_dec_s)
    );

    // Free-running refresh counter, digit index and registered an/seg.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_r <= '0;
            digit_idx_r   <= 2'd0;
            an_r          <= 3'b110;
            seg_r         <= SEG_DIGIT[0];
        end else begin
            if (refresh_cnt_r == CNT_LAST) begin
                refresh_cnt_r <= '0;
            end else begin
                refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
            end
            digit_idx_r <= digit_idx_next_s;
            an_r        <= an_next_s;
            seg_r       <= seg_dec_s;
        end
    end

    assign out  = out_r;
    assign busy = (state_r == CONVERT);
    assign bcd  = bcd_r;
    assign an   = an_r;
    assign seg  = seg_r;

endmodule

// File: tb/tb_out_display.sv
// ---------------------------------------------------------------------------
// tb_out_display: self-checking bench for out_display (REFRESH_DIV = 4).
// Expected BCD comes from decimal arithmetic on the loaded byte; expected
// display comes from the elapsed cycle count since reset.
// ---------------------------------------------------------------------------
module tb_out_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [7:0]  bus;
    logic [7:0]  out;
    logic        busy;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;

    int n_cmp = 0;
    int n_err = 0;
    int ecount = 0;     // edges since the last reset edge
    int exp_val = 0;    // value of the last completed conversion

    out_display #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .bus  (bus),
        .out  (out),
        .busy (busy),
        .bcd  (bcd),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    function automatic logic [11:0] exp_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (idx == 0) return seg_of(o);
        if (idx == 1) return (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
        return (h == 0) ? 7'b1111111 : seg_of(h);
    endfunction

    function automatic logic [2:0] exp_an(input int idx);
        if (idx == 0) return 3'b110;
        if (idx == 1) return 3'b101;
        return 3'b011;
    endfunction

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        bus  = v;
        @(negedge clk);
        load = 1'b0;
        bus  = 8'($urandom);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b still set after %0d cycles, required 0", busy, cycles);
        end
    endtask

    task automatic check_display(input int cycles, input string tag);
        int idx;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            idx = (ecount / DIV) % 3;
            n_cmp++;
            if (an !== exp_an(idx)) begin
                n_err++;
                $display("FAIL %s_an: cycle %0d got %b, required %b", tag, ecount, an, exp_an(idx));
            end
            n_cmp++;
            if (seg !== exp_seg(exp_val, idx)) begin
                n_err++;
                $display("FAIL %s_seg: cycle %0d val %0d got %b, required %b",
                         tag, ecount, exp_val, seg, exp_seg(exp_val, idx));
            end
        end
    endtask

    task automatic test_convert(input int v, input string tag);
        int c;
        logic [11:0] prior;
        prior = exp_bcd(exp_val);
        do_load(8'(v));
        n_cmp++;
        if (out !== 8'(v)) begin
            n_err++;
            $display("FAIL %s_out: got %h, required %h", tag, out, 8'(v));
        end
        n_cmp++;
        if (busy !== 1'b1 || bcd !== prior) begin
            n_err++;
            $display("FAIL %s_start: busy=%b bcd=%h, required busy=1 bcd=%h", tag, busy, bcd, prior);
        end
        wait_idle(c);
        n_cmp++;
        if (c != 8) begin
            n_err++;
            $display("FAIL %s_latency: busy for %0d cycles, required 8", tag, c);
        end
        exp_val = v;
        n_cmp++;
        if (bcd !== exp_bcd(v)) begin
            n_err++;
            $display("FAIL %s_bcd: got %h, required %h", tag, bcd, exp_bcd(v));
        end
        @(negedge clk);
        check_display(3 * DIV, tag);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b0;
        bus  = 8'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out !== 8'h00 || busy !== 1'b0 || bcd !== 12'h000 || an !== 3'b110 || seg !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset: out=%h busy=%b bcd=%h an=%b seg=%b, required 00 0 000 110 1000000",
                     out, busy, bcd, an, seg);
        end
        rst = 1'b0;
        exp_val = 0;
        check_display(3 * DIV, "reset_disp");
    endtask

    task automatic test_restart();
        logic [11:0] prior;
        prior = exp_bcd(exp_val);
        do_load(8'd100);
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (bcd !== prior) begin
                n_err++;
                $display("FAIL restart_hold1: bcd=%h, required %h", bcd, prior);
            end
        end
        do_load(8'd42);
        n_cmp++;
        if (out !== 8'd42 || bcd !== prior) begin
            n_err++;
            $display("FAIL restart_out: out=%0d bcd=%h, required 42 and %h", out, bcd, prior);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1 || bcd !== prior || bcd === exp_bcd(100)) begin
                n_err++;
                $display("FAIL restart_hold2: cycle %0d busy=%b bcd=%h, required 1 and %h", i, busy, bcd, prior);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || bcd !== 12'h042) begin
            n_err++;
            $display("FAIL restart_done: busy=%b bcd=%h, required 0 and 042", busy, bcd);
        end
        exp_val = 42;
    endtask

    task automatic test_back_to_back(input int a, input int b);
        int c;
        do_load(8'(a));
        repeat (7) @(negedge clk);
        do_load(8'(b));
        n_cmp++;
        if (busy !== 1'b1 || bcd !== exp_bcd(a) || out !== 8'(b)) begin
            n_err++;
            $display("FAIL b2b_commit: busy=%b bcd=%h out=%h, required 1 %h %h", busy, bcd, out, exp_bcd(a), 8'(b));
        end
        wait_idle(c);
        n_cmp++;
        if (c != 8 || bcd !== exp_bcd(b)) begin
            n_err++;
            $display("FAIL b2b_second: cycles=%0d bcd=%h, required 8 and %h", c, bcd, exp_bcd(b));
        end
        exp_val = b;
    endtask

    task automatic test_rst_abort();
        do_load(8'd200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out !== 8'd0 || bcd !== 12'd0 || an !== 3'b110 || seg !== 7'b1000000) begin
            n_err++;
            $display("FAIL rst_abort: busy=%b out=%h bcd=%h an=%b seg=%b, required 0 00 000 110 1000000",
                     busy, out, bcd, an, seg);
        end
        rst = 1'b0;
        exp_val = 0;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || bcd !== 12'd0) begin
                n_err++;
                $display("FAIL rst_abort_stay: busy=%b bcd=%h, required 0 and 000", busy, bcd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            test_convert(int'($urandom_range(0, 255)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_convert(255, "ff");
        test_convert(7, "seven");
        test_restart();
        @(negedge clk);
        check_display(3 * DIV, "restart_disp");
        test_back_to_back(99, 250);
        test_convert(0, "zero");
        test_convert(100, "hundred");
        test_rst_abort();
        test_convert(123, "refresh");
        check_display(6 * DIV, "refresh_more");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
